// File: rtl/button_conditioner_if.sv
// button_conditioner_if: bundle of the four-channel pushbutton signals between the button source and the conditioner.
//   btn_raw  [3:0] raw, bouncing button levels (1 = pressed), driven by the button side
//   dpb      [3:0] debounced level per channel, driven by the conditioner
//   scen     [3:0] one-cycle pulse per accepted press
//   mcen     [3:0] one-cycle pulse on press plus auto-repeat pulses while held
//   scen_any       OR of the scen bits
interface button_conditioner_if;
    logic [3:0] btn_raw;
    logic [3:0] dpb;
    logic [3:0] scen;
    logic [3:0] mcen;
    logic       scen_any;
    modport master (output btn_raw, input dpb, scen, mcen, scen_any);
    modport slave  (input btn_raw, output dpb, scen, mcen, scen_any);
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: four independent debounce / single-pulse / auto-repeat channels for raw pushbuttons.
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous, active-high; clears synchronizers, counters, outputs and returns every FSM to IDLE
//   bus    button_conditioner_if.slave: btn_raw in; dpb, scen, mcen, scen_any out (all registered)
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);
    localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_V = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CW    = $clog2(MAX_V);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    // The PULSE and REP_PULSE cycles themselves count toward the repeat spacing,
    // so the waiting states stop two short of the parameter.
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 2);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 2);

    typedef enum logic [2:0] {
        IDLE, DEB_PRESS, PULSE, HOLD, REP_PULSE, REP_WAIT, DEB_RELEASE
    } state_t;

    logic [3:0]    meta_q, sync_q;
    logic [3:0]    dpb_q, scen_q, mcen_q;
    logic [3:0]    dpb_d, scen_d, mcen_d;
    logic          scen_any_q;
    state_t        state_q [4];
    state_t        state_d [4];
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q     <= '0;
            sync_q     <= '0;
            dpb_q      <= '0;
            scen_q     <= '0;
            mcen_q     <= '0;
            scen_any_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            meta_q     <= bus.btn_raw;
            sync_q     <= meta_q;
            dpb_q      <= dpb_d;
            scen_q     <= scen_d;
            mcen_q     <= mcen_d;
            scen_any_q <= |scen_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

    // Counter clears on every transition and only advances while a state is timing.
    always_comb begin
        dpb_d  = '0;
        scen_d = '0;
        mcen_d = '0;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = '0;
            case (state_q[i])
                IDLE:        if (sync_q[i]) state_d[i] = DEB_PRESS;
                DEB_PRESS:   if (!sync_q[i]) state_d[i] = IDLE;
                             else if (cnt_q[i] == DEB_LAST) state_d[i] = PULSE;
                             else cnt_d[i] = cnt_q[i] + CW'(1);
                PULSE:       state_d[i] = HOLD;
                HOLD:        if (!sync_q[i]) state_d[i] = DEB_RELEASE;
                             else if (cnt_q[i] == DLY_LAST) state_d[i] = REP_PULSE;
                             else cnt_d[i] = cnt_q[i] + CW'(1);
                REP_PULSE:   state_d[i] = REP_WAIT;
                REP_WAIT:    if (!sync_q[i]) state_d[i] = DEB_RELEASE;
                             else if (cnt_q[i] == PER_LAST) state_d[i] = REP_PULSE;
                             else cnt_d[i] = cnt_q[i] + CW'(1);
                // A bounce back to pressed resumes holding without a new press pulse.
                DEB_RELEASE: if (sync_q[i]) state_d[i] = HOLD;
                             else if (cnt_q[i] == DEB_LAST) state_d[i] = IDLE;
                             else cnt_d[i] = cnt_q[i] + CW'(1);
                default:     state_d[i] = IDLE;
            endcase
            dpb_d[i]  = (state_q[i] != IDLE) && (state_q[i] != DEB_PRESS);
            scen_d[i] = state_q[i] == PULSE;
            mcen_d[i] = (state_q[i] == PULSE) || (state_q[i] == REP_PULSE);
        end
    end

    assign bus.dpb      = dpb_q;
    assign bus.scen     = scen_q;
    assign bus.mcen     = mcen_q;
    assign bus.scen_any = scen_any_q;
endmodule
